// File: rtl/hamming_scrub_ctrl.sv
// hamming_scrub_ctrl
//   Background scrubber for SEC-DED protected storage (8-bit data, 13-bit
//   codewords). Every INTERVAL idle cycles it reads one word through a shared
//   memory port and checks it. A single-bit error is counted and the repaired
//   codeword is written back. An uncorrectable word is counted and logged.
//   The scrubber always yields to the host: it holds its request until the
//   arbiter grants it.
//
//   Codeword: bit0 = even parity over bits 12:1; Hamming parity at positions
//   1,2,4,8; data at positions 3,5,6,7,9,10,11,12.
//
//   Build option: HAMMING_SCRUB_WRITEBACK_EN
//     defined   - single errors are written back (WR_REQ state present)
//     undefined - report-only: single errors are counted, never written,
//                 and mem_we is tied to 0
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   enable             scrubbing allowed (the word in flight always completes)
//   mem_req/we/addr    memory request; held stable until mem_gnt
//   mem_wdata          corrected codeword for a write-back
//   mem_gnt            arbiter accepts the request this cycle
//   mem_rdata/rvalid   read return, one or more cycles after a read grant
//   busy               FSM not in IDLE
//   pass_done          one-cycle pulse when the address wraps to 0
//   ce_count/ue_count  saturating corrected / uncorrectable error counters
//   ue_irq, ue_addr    pulse and address of the latest uncorrectable word
module hamming_scrub_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int DEPTH    = 256,
    parameter int INTERVAL = 1024,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [12:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic [12:0]       mem_rdata,
    input  logic              mem_rvalid,
    output logic              busy,
    output logic              pass_done,
    output logic [CNT_W-1:0]  ce_count,
    output logic [CNT_W-1:0]  ue_count,
    output logic              ue_irq,
    output logic [ADDR_W-1:0] ue_addr
);
    localparam int                TMR_W     = $clog2(INTERVAL);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(INTERVAL - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_CHECK,
`ifdef HAMMING_SCRUB_WRITEBACK_EN
        S_WR_REQ,
`endif
        S_NEXT
    } state_t;

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [12:0]       rdata_q, rdata_d;
    logic [CNT_W-1:0]  ce_q, ce_d;
    logic [CNT_W-1:0]  ue_q, ue_d;
    logic [ADDR_W-1:0] ue_addr_q, ue_addr_d;
    logic              ue_irq_q, ue_irq_d;
`ifdef HAMMING_SCRUB_WRITEBACK_EN
    logic [12:0]       wdata_q, wdata_d;
`endif

    logic [3:0] syn;
    logic       par;
    logic       is_single;
    logic       is_ue;

    // Syndrome over positions 1..12 plus overall parity of the captured word.
    // syn==0 with par==1 points at bit0, so (1 << syn) is the flip mask for
    // every correctable case.
    always_comb begin
        syn = 4'd0;
        for (int i = 1; i <= 12; i++) begin
            if (rdata_q[i]) syn = syn ^ 4'(i);
        end
        par       = ^rdata_q;
        is_single = par && (syn <= 4'd12);
        is_ue     = (par && (syn > 4'd12)) || (!par && (syn != 4'd0));
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        addr_d    = addr_q;
        rdata_d   = rdata_q;
        ce_d      = ce_q;
        ue_d      = ue_q;
        ue_addr_d = ue_addr_q;
        ue_irq_d  = 1'b0;
`ifdef HAMMING_SCRUB_WRITEBACK_EN
        wdata_d   = wdata_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!enable) begin
                    timer_d = '0;
                end else if (timer_q == TMR_LAST) begin
                    timer_d = '0;
                    state_d = S_RD_REQ;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_RD_REQ: begin
                if (mem_gnt) state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (mem_rvalid) begin
                    rdata_d = mem_rdata;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                state_d = S_NEXT;
                if (is_single) begin
                    if (ce_q != '1) ce_d = ce_q + 1'b1;
`ifdef HAMMING_SCRUB_WRITEBACK_EN
                    wdata_d = rdata_q ^ (13'd1 << syn);
                    state_d = S_WR_REQ;
`endif
                end else if (is_ue) begin
                    if (ue_q != '1) ue_d = ue_q + 1'b1;
                    ue_addr_d = addr_q;
                    ue_irq_d  = 1'b1;
                end
            end
`ifdef HAMMING_SCRUB_WRITEBACK_EN
            S_WR_REQ: begin
                if (mem_gnt) state_d = S_NEXT;
            end
`endif
            S_NEXT: begin
                addr_d  = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
                timer_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            addr_q    <= '0;
            rdata_q   <= '0;
            ce_q      <= '0;
            ue_q      <= '0;
            ue_addr_q <= '0;
            ue_irq_q  <= 1'b0;
`ifdef HAMMING_SCRUB_WRITEBACK_EN
            wdata_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            addr_q    <= addr_d;
            rdata_q   <= rdata_d;
            ce_q      <= ce_d;
            ue_q      <= ue_d;
            ue_addr_q <= ue_addr_d;
            ue_irq_q  <= ue_irq_d;
`ifdef HAMMING_SCRUB_WRITEBACK_EN
            wdata_q   <= wdata_d;
`endif
        end
    end

    // Request outputs are decoded from the state register only, so they stay
    // stable while waiting for a grant and drop to 0 as soon as rst rises.
`ifdef HAMMING_SCRUB_WRITEBACK_EN
    assign mem_we    = (state_q == S_WR_REQ);
    assign mem_wdata = mem_we ? wdata_q : 13'd0;
`else
    assign mem_we    = 1'b0;
    assign mem_wdata = 13'd0;
`endif
    assign mem_req   = (state_q == S_RD_REQ) || mem_we;
    assign mem_addr  = mem_req ? addr_q : '0;
    assign busy      = (state_q != S_IDLE);
    assign pass_done = (state_q == S_NEXT) && (addr_q == ADDR_LAST);
    assign ce_count  = ce_q;
    assign ue_count  = ue_q;
    assign ue_irq    = ue_irq_q;
    assign ue_addr   = ue_addr_q;

endmodule

// File: tb/tb_hamming_scrub_ctrl.sv
// Directed bench for hamming_scrub_ctrl (DEPTH=4, INTERVAL=4). A small
// memory/arbiter responder runs on the falling edge; the stimulus and all
// checks run in one initial block, sampling 1 time unit after the falling edge.
// Codewords used (hand-encoded):
//   encode(0x00)=0x0000  encode(0xA5)=0x144E  encode(0x3C)=0x06C5
//   0x140E = 0x144E with bit6 flipped          (single, syndrome 6)
//   0x04CD = 0x06C5 with bits 3 and 9 flipped  (double, syndrome 10)
//   0x0001 = 0x0000 with bit0 flipped          (single at bit0)
//   0x0112 = bits 1,4,8 set                    (parity 1, syndrome 13)
module tb_hamming_scrub_ctrl;
    logic        clk;
    logic        rst;
    logic        enable;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [12:0] mem_wdata;
    logic        mem_gnt;
    logic [12:0] mem_rdata;
    logic        mem_rvalid;
    logic        busy;
    logic        pass_done;
    logic [15:0] ce_count;
    logic [15:0] ue_count;
    logic        ue_irq;
    logic [7:0]  ue_addr;

    hamming_scrub_ctrl #(.ADDR_W(8), .DEPTH(4), .INTERVAL(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid), .busy(busy), .pass_done(pass_done),
        .ce_count(ce_count), .ue_count(ue_count), .ue_irq(ue_irq),
        .ue_addr(ue_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // responder state and logs
    logic [12:0] mem [4];
    logic        rgnt_en, wgnt_en;
    logic        rd_pend;
    logic [1:0]  rd_a;
    int          rd_cnt, wr_cnt, pass_cnt, irq_cyc;
    int          rd_addr_log [16];
    int          wr_addr_log [16];
    logic [12:0] wr_data_log [16];
    int          irq_addr_log[16];

    always @(negedge clk) begin
        mem_rvalid = 1'b0;
        mem_rdata  = 13'h1FFF;
        if (rd_pend) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem[rd_a];
            rd_pend    = 1'b0;
        end
        mem_gnt = mem_req && (mem_we ? wgnt_en : rgnt_en);
        if (mem_gnt) begin
            if (mem_we) begin
                if (wr_cnt < 16) begin
                    wr_addr_log[wr_cnt] = int'(mem_addr);
                    wr_data_log[wr_cnt] = mem_wdata;
                end
                wr_cnt++;
                mem[mem_addr[1:0]] = mem_wdata;
            end else begin
                rd_pend = 1'b1;
                rd_a    = mem_addr[1:0];
                if (rd_cnt < 16) rd_addr_log[rd_cnt] = int'(mem_addr);
                rd_cnt++;
            end
        end
        if (pass_done) pass_cnt++;
        if (ue_irq) begin
            if (irq_cyc < 16) irq_addr_log[irq_cyc] = int'(ue_addr);
            irq_cyc++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rd_cnt  = 0;
        wr_cnt  = 0;
        irq_cyc = 0;
    endtask

    task automatic wait_pass(input string tag, input int max_cyc);
        int start;
        int n;
        start = pass_cnt;
        n = 0;
        while (pass_cnt == start && n < max_cyc) begin
            tick();
            n++;
        end
        chk(tag, 32'(pass_cnt != start), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},    32'(mem_req),   32'd0);
        chk({tag, "_we"},     32'(mem_we),    32'd0);
        chk({tag, "_addr"},   32'(mem_addr),  32'd0);
        chk({tag, "_wdata"},  32'(mem_wdata), 32'd0);
        chk({tag, "_busy"},   32'(busy),      32'd0);
        chk({tag, "_pdone"},  32'(pass_done), 32'd0);
        chk({tag, "_ce"},     32'(ce_count),  32'd0);
        chk({tag, "_ue"},     32'(ue_count),  32'd0);
        chk({tag, "_irq"},    32'(ue_irq),    32'd0);
        chk({tag, "_ueaddr"}, 32'(ue_addr),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; enable = 1'b0; rgnt_en = 1'b1; wgnt_en = 1'b1;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 13'd0;
        rd_pend = 1'b0; rd_a = 2'd0; pass_cnt = 0;
        clear_logs();
        mem[0] = 13'h0000; mem[1] = 13'h144E; mem[2] = 13'h06C5; mem[3] = 13'h0000;
        tick(); tick();

        // reset state
        chk_all_zero("rst");

        // A: clean pass, reads 0..3 then pass_done; no errors, no writes
        rst = 1'b0; enable = 1'b1;
        wait_pass("a_pass_seen", 100);
        enable = 1'b0;
        chk("a_rd_cnt", 32'(rd_cnt), 32'd4);
        for (int i = 0; i < 4; i++) chk("a_rd_addr", 32'(rd_addr_log[i]), 32'(i));
        chk("a_ce", 32'(ce_count), 32'd0);
        chk("a_ue", 32'(ue_count), 32'd0);
        chk("a_wr_cnt", 32'(wr_cnt), 32'd0);
        repeat (12) tick();
        chk("a_idle_no_rd", 32'(rd_cnt), 32'd4);
        chk("a_idle_busy", 32'(busy), 32'd0);

        // B: errors in every word; pass resumes at addr 0
        mem[0] = 13'h0001; mem[1] = 13'h04CD; mem[2] = 13'h140E; mem[3] = 13'h0112;
        clear_logs();
        enable = 1'b1;
        wait_pass("b_pass_seen", 120);
        enable = 1'b0;
        chk("b_rd_cnt", 32'(rd_cnt), 32'd4);
        chk("b_first_rd", 32'(rd_addr_log[0]), 32'd0);
        chk("b_ce", 32'(ce_count), 32'd2);
        chk("b_ue", 32'(ue_count), 32'd2);
        chk("b_irq_cycles", 32'(irq_cyc), 32'd2);
        chk("b_irq_addr0", 32'(irq_addr_log[0]), 32'd1);
        chk("b_irq_addr1", 32'(irq_addr_log[1]), 32'd3);
        chk("b_ue_addr", 32'(ue_addr), 32'd3);
`ifdef HAMMING_SCRUB_WRITEBACK_EN
        chk("b_wr_cnt", 32'(wr_cnt), 32'd2);
        chk("b_wr_addr0", 32'(wr_addr_log[0]), 32'd0);
        chk("b_wr_data0", 32'(wr_data_log[0]), 32'h0000);
        chk("b_wr_addr1", 32'(wr_addr_log[1]), 32'd2);
        chk("b_wr_data1", 32'(wr_data_log[1]), 32'h144E);
        chk("b_mem1_untouched", 32'(mem[1]), 32'h04CD);
`else
        chk("b_wr_cnt", 32'(wr_cnt), 32'd0);
        chk("b_mem2_untouched", 32'(mem[2]), 32'h140E);
`endif
        repeat (4) tick();

        // C: grant withheld; request held stable; enable dropped mid-word
        mem[0] = 13'h0000;
        clear_logs();
        rgnt_en = 1'b0;
        enable  = 1'b1;
        n = 0;
        while (!mem_req && n < 40) begin tick(); n++; end
        chk("c_req_seen", 32'(mem_req), 32'd1);
        for (int i = 0; i < 10; i++) begin
            if (i == 5) enable = 1'b0;
            chk("c_stall_req", 32'(mem_req), 32'd1);
            chk("c_stall_addr", 32'(mem_addr), 32'd0);
            tick();
        end
        chk("c_stall_we", 32'(mem_we), 32'd0);
        rgnt_en = 1'b1;
        n = 0;
        while (rd_cnt == 0 && n < 20) begin tick(); n++; end
        chk("c_rd_done", 32'(rd_cnt), 32'd1);
        repeat (12) tick();
        chk("c_no_more_rd", 32'(rd_cnt), 32'd1);
        chk("c_busy", 32'(busy), 32'd0);
        chk("c_ce", 32'(ce_count), 32'd2);

        // D: reset while a request is pending (the write-back when present)
        mem[1] = 13'h140E;
        clear_logs();
        enable = 1'b1;
`ifdef HAMMING_SCRUB_WRITEBACK_EN
        wgnt_en = 1'b0;
        n = 0;
        while (!(mem_req && mem_we) && n < 40) begin tick(); n++; end
        chk("d_wr_pending", 32'(mem_req && mem_we), 32'd1);
        chk("d_wr_addr", 32'(mem_addr), 32'd1);
        chk("d_wr_data", 32'(mem_wdata), 32'h144E);
        chk("d_ce_before", 32'(ce_count), 32'd3);
`else
        rgnt_en = 1'b0;
        n = 0;
        while (!mem_req && n < 40) begin tick(); n++; end
        chk("d_rd_pending", 32'(mem_req), 32'd1);
        chk("d_rd_addr", 32'(mem_addr), 32'd1);
`endif
        #2 rst = 1'b1;
        #1 chk_all_zero("d_async");
        rgnt_en = 1'b1; wgnt_en = 1'b1;
        tick(); tick();
        clear_logs();
        rst = 1'b0;
        n = 0;
        while (!mem_req && n < 20) begin tick(); n++; end
        chk("d_restart_lat", 32'(n), 32'd4);
        chk("d_restart_addr", 32'(mem_addr), 32'd0);
        chk("d_restart_we", 32'(mem_we), 32'd0);
        enable = 1'b0;
        n = 0;
        while (busy && n < 20) begin tick(); n++; end
        chk("d_restart_ce", 32'(ce_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hamming_scrub_ctrl.md
Name: hamming_scrub_ctrl

Overview:
- Background memory scrubber for SEC-DED protected storage: 8-bit data, 13-bit codewords.
- Periodically reads each word over a shared memory port, checks it, and writes back the corrected codeword on single-bit errors.
- Keeps error counters and logs uncorrectable addresses.
- Sits between the memory array and the host-side port arbiter. It is the requester that always yields to the host.

Parameters:
- ADDR_W, 8, memory address width.
- DEPTH, 256, number of words scrubbed per pass (≤ 2^ADDR_W).
- INTERVAL, 1024, idle cycles between successive word scrubs (≥ 2).
- CNT_W, 16, width of the error counters.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- enable  in  1  scrubbing allowed
- mem_req  out  1  scrubber requests the memory port
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  13  codeword to write
- mem_gnt  in  1  arbiter accepts the request this cycle
- mem_rdata  in  13  read codeword
- mem_rvalid  in  1  mem_rdata valid; arrives one or more cycles after a read grant
- busy  out  1  FSM not in IDLE
- pass_done  out  1  one-cycle pulse after the last address of a pass
- ce_count  out  CNT_W  corrected (single) errors, saturating
- ue_count  out  CNT_W  uncorrectable errors, saturating
- ue_irq  out  1  one-cycle pulse per uncorrectable word
- ue_addr  out  ADDR_W  address of the most recent uncorrectable word

Behaviour:
- Codeword layout:
  - bit0 = even parity over bits 12:1.
  - Hamming parity at positions 1, 2, 4, 8.
  - Data at positions 3, 5, 6, 7, 9, 10, 11, 12.
- Syndrome s[3:0] = XOR of the indices of all set bits among positions 1..12. Overall parity p = XOR of bits 12:0.
- Classification, registered in the CHECK state:
  - s=0, p=0: clean.
  - p=1, s=0: single error at bit0; flip bit0.
  - p=1, 1≤s≤12: single error; flip bit s.
  - p=1, s>12: uncorrectable.
  - p=0, s≠0: uncorrectable (double error).
- FSM states: IDLE, RD_REQ, RD_WAIT, CHECK, WR_REQ, NEXT.
  - IDLE: timer counts while enable=1. It clears when enable=0. On reaching INTERVAL-1, go to RD_REQ.
  - RD_REQ: mem_req=1, mem_we=0, mem_addr=addr. Hold until mem_gnt=1, then go to RD_WAIT.
  - RD_WAIT: capture mem_rdata on mem_rvalid, then go to CHECK. A mem_rvalid outside RD_WAIT is ignored.
  - CHECK: one cycle.
    - Clean: go to NEXT.
    - Single error: ce_count++, go to WR_REQ.
    - Uncorrectable: ue_count++, ue_addr←addr, ue_irq pulse, go to NEXT. No write.
  - WR_REQ: mem_req=1, mem_we=1, mem_wdata = corrected codeword. Hold until mem_gnt, then go to NEXT.
  - NEXT: addr += 1, wrapping from DEPTH-1 to 0. The wrap cycle pulses pass_done. Timer clears; go to IDLE.
- mem_req, mem_we, mem_addr and mem_wdata are stable while waiting for mem_gnt. mem_req=0 in all other states.
- Latency: minimum 6 cycles from timer expiry to return to IDLE for a corrected word with immediate grant and rvalid one cycle after grant.
- enable deasserted mid-word: the current word completes; the FSM then stays in IDLE. addr is retained, so the pass resumes where it left off.
- Counters saturate at 2^CNT_W-1. Holding at max is not an error.
- Reset (async, any state): FSM→IDLE, timer=0, addr=0, ce_count=0, ue_count=0, ue_addr=0. All outputs 0, including mem_req, mem_we, mem_addr, mem_wdata, busy, pass_done and ue_irq.
- An abandoned in-flight read after reset is the arbiter's responsibility; the scrubber ignores any mem_rvalid it sees while in IDLE.

Optional Feature:
- HAMMING_SCRUB_WRITEBACK_EN
  - Defined: single errors are written back as above.
  - Undefined: the WR_REQ state is removed. Single errors only increment ce_count and go straight to NEXT, so mem_we is constantly 0. This is report-only mode for read-only or externally managed memories.

Test Plan:
- Clean memory, DEPTH=4, INTERVAL=4, immediate grants:
  - Four reads at addr 0,1,2,3, then pass_done.
  - ce_count=0, ue_count=0, no writes; the next read is at addr 0.
- Word 2 = encode(0xA5) with position 6 flipped:
  - ce_count=1; write to addr 2 with mem_wdata = encode(0xA5) (bit6 restored).
  - Without the macro: no write, ce_count=1.
- Word 1 = encode(0x3C) with bits 3 and 9 flipped:
  - ue_count=1, ue_addr=1, one-cycle ue_irq, no write.
- Word 0 = encode(0x00) with bit0 flipped:
  - Classified single; write back 13'h0000.
- mem_gnt held low for 10 cycles during RD_REQ:
  - mem_req and mem_addr stay stable, with no timer advance.
  - The read completes after the grant.
- rst asserted during WR_REQ:
  - Outputs go to 0 asynchronously, counters clear.
  - After release, scrubbing restarts at addr 0 after INTERVAL cycles.
